// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, funct and ALU control encodings for the multi-cycle MIPS core
package mips_pkg;

  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_J      = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_X4 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_reg_file.sv
// rtl/mips_reg_file.sv - 32x32 register file, two async read ports, one sync write port, r0 fixed at 0
module mips_reg_file (
  input  logic        clk,
  input  logic        rstn,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // No write-to-read bypass: a same-cycle read sees the pre-write value.
  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];

endmodule

// File: rtl/mips_multicycle_datapath.sv
// rtl/mips_multicycle_datapath.sv - multi-cycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, ALU and muxes
module mips_multicycle_datapath
  import mips_pkg::*;
#(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pc_write,
  input  logic [1:0]       pc_src,
  input  logic             branch,
  input  logic             mem_write,
  input  logic             mem_to_reg,
  input  logic             reg_dst,
  input  logic             reg_write,
  input  logic             IorD,
  input  logic             ir_write,
  input  logic             alu_src_A,
  input  logic [1:0]       alu_src_B,
  input  logic [2:0]       alu_control,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic             zero
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, mdr_q, a_q, b_q, aluout_q;
  logic [WIDTH-1:0] rd1, rd2, wd, signimm, src_a, src_b, alu_result;
  logic [4:0]       wa;
  logic             pc_en;

  assign wa = reg_dst ? ir_q[15:11] : ir_q[20:16];
  assign wd = mem_to_reg ? mdr_q : aluout_q;

  mips_reg_file u_reg_file (
    .clk   (clk),
    .rstn  (rstn),
    .we_i  (reg_write),
    .wa_i  (wa),
    .wd_i  (wd),
    .ra1_i (ir_q[25:21]),
    .ra2_i (ir_q[20:16]),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  assign signimm = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign src_a   = alu_src_A ? a_q : pc_q;

  always_comb begin
    src_b = b_q;
    case (alu_src_B)
      SRCB_REG:    src_b = b_q;
      SRCB_FOUR:   src_b = WIDTH'(4);
      SRCB_IMM:    src_b = signimm;
      SRCB_IMM_X4: src_b = {signimm[WIDTH-3:0], 2'b00};
      default:     src_b = b_q;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  always_comb begin
    pc_d = aluout_q;
    case (pc_src)
      PCSRC_ALU:  pc_d = alu_result;
      PCSRC_JUMP: pc_d = {pc_q[WIDTH-1:WIDTH-4], ir_q[25:0], 2'b00};
      default:    pc_d = aluout_q;
    endcase
  end

  assign pc_en = pc_write | (branch & zero);

  // MDR, A, B and ALUOut are free-running inter-cycle latches; only PC and IR are gated.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      if (pc_en)    pc_q <= pc_d;
      if (ir_write) ir_q <= mem_rdata;
      mdr_q    <= mem_rdata;
      a_q      <= rd1;
      b_q      <= rd2;
      aluout_q <= alu_result;
    end
  end

  assign mem_addr  = IorD ? aluout_q : pc_q;
  assign mem_wdata = b_q;
  assign mem_we    = mem_write;
  assign opcode    = ir_q[31:26];
  assign funct     = ir_q[5:0];

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// tb/tb_mips_multicycle_datapath.sv - scoreboard bench with architectural reference model
module tb_mips_multicycle_datapath;

  logic        clk, rstn;
  logic        pc_write, branch, mem_write, mem_to_reg, reg_dst, reg_write, IorD, ir_write, alu_src_A;
  logic [1:0]  pc_src, alu_src_B;
  logic [2:0]  alu_control;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, zero;
  logic [5:0]  opcode, funct;

  mips_multicycle_datapath #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn), .pc_write(pc_write), .pc_src(pc_src), .branch(branch),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .IorD(IorD), .ir_write(ir_write), .alu_src_A(alu_src_A), .alu_src_B(alu_src_B),
    .alu_control(alu_control), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .opcode(opcode), .funct(funct), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, wdata;
    logic        we, zero;
    logic [5:0]  opc, fn;
    bit          pin_a, pin_w, pin_z;
    logic [31:0] pa, pw;
    logic        pz;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;

  // Architectural reference state
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;

  bit          chk_en = 0;
  bit          pin_a = 0, pin_w = 0, pin_z = 0;
  logic [31:0] pin_av, pin_wv;
  logic        pin_zv;

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      automatic exp_t e = q.pop_front();
      cmp("mem_addr", mem_addr, e.addr);
      cmp("mem_wdata", mem_wdata, e.wdata);
      cmp("mem_we", {31'd0, mem_we}, {31'd0, e.we});
      cmp("opcode", {26'd0, opcode}, {26'd0, e.opc});
      cmp("funct", {26'd0, funct}, {26'd0, e.fn});
      cmp("zero", {31'd0, zero}, {31'd0, e.zero});
      if (e.pin_a) cmp("directed_addr", mem_addr, e.pa);
      if (e.pin_w) cmp("directed_wdata", mem_wdata, e.pw);
      if (e.pin_z) cmp("directed_zero", {31'd0, zero}, {31'd0, e.pz});
    end
  end

  function automatic logic [31:0] m_alu(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
    case (op)
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b111:  return (signed'(x) < signed'(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic op(input bit pw, input logic [1:0] ps, input bit br, input bit mw, input bit m2r,
                    input bit rdst, input bit rw, input bit iord, input bit irw, input bit sa,
                    input logic [1:0] sb, input logic [2:0] ac, input logic [31:0] rd);
    logic [31:0] imm, opa, opb, res, npc, rd1, rd2, wdat;
    logic [4:0]  wa;
    exp_t e;
    pc_write = pw; pc_src = ps; branch = br; mem_write = mw; mem_to_reg = m2r; reg_dst = rdst;
    reg_write = rw; IorD = iord; ir_write = irw; alu_src_A = sa; alu_src_B = sb;
    alu_control = ac; mem_rdata = rd;
    imm = 32'(signed'(m_ir[15:0]));
    opa = sa ? m_a : m_pc;
    opb = (sb == 2'd0) ? m_b : (sb == 2'd1) ? 32'd4 : (sb == 2'd2) ? imm : imm * 4;
    res = m_alu(opa, opb, ac);
    e.addr = iord ? m_aluout : m_pc;  e.wdata = m_b;  e.we = mw;
    e.opc = m_ir[31:26];  e.fn = m_ir[5:0];  e.zero = (res == 0);
    e.pin_a = pin_a; e.pa = pin_av; e.pin_w = pin_w; e.pw = pin_wv; e.pin_z = pin_z; e.pz = pin_zv;
    if (chk_en) q.push_back(e);
    pin_a = 0; pin_w = 0; pin_z = 0;
    @(posedge clk);
    #1;
    if (!rstn) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      m_pc = 0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0;
    end else begin
      rd1 = m_regs[m_ir[25:21]];
      rd2 = m_regs[m_ir[20:16]];
      wa = rdst ? m_ir[15:11] : m_ir[20:16];
      wdat = m2r ? m_mdr : m_aluout;
      npc = (ps == 2'd0) ? res : (ps == 2'd2) ? {m_pc[31:28], m_ir[25:0], 2'b00} : m_aluout;
      if (pw || (br && res == 0)) m_pc = npc;
      if (rw && wa != 0) m_regs[wa] = wdat;
      if (irw) m_ir = rd;
      m_mdr = rd; m_a = rd1; m_b = rd2; m_aluout = res;
    end
  endtask

  task automatic idle();
    op(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'b000, $urandom);
  endtask

  task automatic fetch(input logic [31:0] instr);
    op(1, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd1, 3'b010, instr);
  endtask

  task automatic decode();
    op(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 3'b010, $urandom);
  endtask

  task automatic load_reg(input logic [4:0] r, input logic [31:0] val);
    fetch({6'b100011, 5'd0, r, 16'd0});
    decode();
    op(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'b010, 0);
    op(0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 3'b000, val);
    op(0, 2'd0, 0, 0, 1, 0, 1, 0, 0, 0, 2'd0, 3'b000, 0);
  endtask

  task automatic show_reg(input logic [4:0] r, input logic [31:0] val);
    fetch({6'b101011, 5'd0, r, 16'd0});
    decode();
    pin_w = 1; pin_wv = val;
    idle();
  endtask

  task automatic rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [5:0] fn, input logic [2:0] ac, input logic exp_zero);
    fetch({6'b000000, rs, rt, rd, 5'd0, fn});
    decode();
    pin_z = 1; pin_zv = exp_zero;
    op(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, ac, 0);
    op(0, 2'd0, 0, 0, 0, 1, 1, 0, 0, 0, 2'd0, 3'b000, 0);
  endtask

  task automatic beq_at(input logic exp_zero, input logic [31:0] exp_pc_off);
    logic [31:0] fpc;
    fpc = m_pc;
    fetch({6'b000100, 5'd1, 5'd2, 16'd3});
    decode();
    pin_z = 1; pin_zv = exp_zero;
    op(0, 2'd1, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 3'b110, 0);
    pin_a = 1; pin_av = fpc + exp_pc_off;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 0;
    chk_en = 0;
    op(1, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd1, 3'b010, 32'hFFFF_FFFF);
    chk_en = 1;
    pin_a = 1; pin_av = 32'h0;
    op(1, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd1, 3'b010, 32'hFFFF_FFFF);
    rstn = 1;

    // fetch and lw r8 <- DEADBEEF
    pin_a = 1; pin_av = 32'h0;
    fetch(32'h8C08_0004);
    pin_a = 1; pin_av = 32'h4;
    decode();
    op(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'b010, 0);
    pin_a = 1; pin_av = 32'h4;
    op(0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 3'b000, 32'hDEAD_BEEF);
    op(0, 2'd0, 0, 0, 1, 0, 1, 0, 0, 0, 2'd0, 3'b000, 0);
    show_reg(5'd8, 32'hDEAD_BEEF);

    // slt both operand orders
    load_reg(5'd1, 32'hFFFF_FFFF);
    load_reg(5'd2, 32'd1);
    rtype(5'd1, 5'd2, 5'd3, 6'b101010, 3'b111, 1'b0);
    show_reg(5'd3, 32'd1);
    rtype(5'd2, 5'd1, 5'd3, 6'b101010, 3'b111, 1'b1);
    show_reg(5'd3, 32'd0);

    // beq taken lands at fetch+4+12, not taken stays at fetch+4
    load_reg(5'd1, 32'd5);
    load_reg(5'd2, 32'd5);
    beq_at(1'b1, 32'd16);
    load_reg(5'd2, 32'd6);
    beq_at(1'b0, 32'd4);

    // jump from PC=1000_0004
    load_reg(5'd4, 32'h1000_0000);
    fetch({6'b000000, 5'd4, 5'd0, 16'd0});
    decode();
    op(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 3'b010, 0);
    op(1, 2'd1, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 3'b000, {6'b000010, 26'h0000040});
    pin_a = 1; pin_av = 32'h1000_0004;
    op(1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'b000, 0);
    pin_a = 1; pin_av = 32'h1000_0100;
    idle();

    // r0 protection, then reset during a lw writeback to r5
    load_reg(5'd0, 32'd7);
    show_reg(5'd0, 32'd0);
    fetch({6'b100011, 5'd0, 5'd5, 16'd0});
    decode();
    op(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'b010, 0);
    op(0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 3'b000, 32'd99);
    rstn = 0;
    op(1, 2'd0, 0, 0, 1, 0, 1, 0, 1, 0, 2'd1, 3'b010, 32'd99);
    rstn = 1;
    pin_a = 1; pin_av = 32'h0;
    idle();
    show_reg(5'd5, 32'd0);

    // randomized control sequences with occasional reset
    for (int i = 0; i < 600; i++) begin
      rstn = ($urandom_range(0, 49) != 0);
      op($urandom_range(0, 3) == 0, 2'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
         $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
         $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom), 3'($urandom),
         ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom);
    end
    rstn = 1;

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_datapath.md
Name: mips_multicycle_datapath

Overview:
Datapath of the multi-cycle MIPS core. It sits directly downstream of the control FSM and consumes all of its control outputs: pc_write, pc_src, branch, mem_write, mem_to_reg, reg_dst, reg_write, IorD, ir_write, alu_src_A, alu_src_B and alu_control. It holds the architectural state (PC, register file) and the non-architectural inter-cycle registers (IR, MDR, A, B, ALUOut). It drives the unified instruction/data memory port and returns opcode, funct and zero to the controller.

Parameters:
WIDTH, 32, datapath word width; only 32 is supported.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rstn  in  1  synchronous, active-low reset.
pc_write  in  1  unconditional PC load enable.
pc_src  in  2  next-PC select.
branch  in  1  conditional PC load enable (qualified by zero).
mem_write  in  1  memory write strobe.
mem_to_reg  in  1  register write-data select.
reg_dst  in  1  register write-address select.
reg_write  in  1  register file write enable.
IorD  in  1  memory address select.
ir_write  in  1  IR load enable.
alu_src_A  in  1  ALU A operand select.
alu_src_B  in  2  ALU B operand select.
alu_control  in  3  ALU operation.
mem_addr  out  32  memory byte address.
mem_wdata  out  32  memory write data.
mem_we  out  1  memory write enable.
mem_rdata  in  32  memory read data; combinational, same-cycle.
opcode  out  6  IR[31:26].
funct  out  6  IR[5:0].
zero  out  1  high when the ALU result equals 0.

Behaviour:
- Reset: when rstn=0 at a clock edge:
  - PC <= RESET_PC.
  - IR, MDR, A, B and ALUOut <= 0.
  - All 32 GPRs <= 0.
  - Reset overrides every enable, including reg_write, ir_write and pc_write.
- Outputs after reset: opcode=0, funct=0, mem_addr=RESET_PC, mem_we=mem_write (pass-through), zero reflects the combinational ALU result.
- Reset asserted mid-instruction discards all in-flight state; there is no partial commit.
- Memory port:
  - mem_addr = IorD ? ALUOut : PC.
  - mem_wdata = B.
  - mem_we = mem_write.
- IR: loads mem_rdata when ir_write=1; otherwise holds.
- MDR, A, B, ALUOut: load every cycle with no enable.
  - MDR <= mem_rdata.
  - A <= rd1, B <= rd2.
  - ALUOut <= alu_result.
- Register file:
  - Read addresses: rs = IR[25:21], rt = IR[20:16]; reads are asynchronous.
  - Write address: reg_dst ? IR[15:11] : IR[20:16].
  - Write data: mem_to_reg ? MDR : ALUOut.
  - Write is synchronous when reg_write=1.
  - Writes to r0 are ignored; r0 always reads 0.
  - A read of the register being written in the same cycle returns the old value (no bypass).
- Immediate: signimm = sign-extension of IR[15:0] to 32 bits.
- ALU operand A: alu_src_A = 0 selects PC; 1 selects A.
- ALU operand B:
  - 00 selects B.
  - 01 selects 32'd4.
  - 10 selects signimm.
  - 11 selects signimm << 2.
- alu_control codes:
  - 010 ADD, 110 SUB: modulo 2^32, no overflow flag or exception.
  - 000 AND, 001 OR.
  - 111 SLT: signed compare, result 1 or 0.
  - Any other code: result 0.
- zero = (alu_result == 32'd0), combinational.
- Next PC:
  - pc_src = 00 selects alu_result.
  - 01 selects ALUOut.
  - 10 selects {PC[31:28], IR[25:0], 2'b00}.
  - 11 selects ALUOut.
- PC load enable: pc_en = pc_write | (branch & zero). If pc_write and branch are both high, the PC loads once. If pc_en=0, the PC holds.
- Latency: there is no combinational path from any control input to a state element other than through the next-edge update. mem_addr changes combinationally with IorD.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode constants: LW 100011, SW 101011, R-type 000000, BEQ 000100, ADDI 001000, J 000010.
  - Funct constants: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - ALU control codes.
  - The controller uses the same package.
- One sub-module, mips_reg_file: 32x32, 2 asynchronous read ports, 1 synchronous write port, r0 hardwired to 0, synchronous reset clears all entries.
- The ALU, the muxes and the pipeline registers stay inline.

Test Plan:
- Reset then fetch: rstn low 2 cycles, then ir_write=1, alu_src_A=0, alu_src_B=01, pc_write=1, mem_rdata=32'h8C08_0004 -> IR=8C080004, opcode=100011, PC=4, mem_addr=4.
- lw sequence: r0 base, imm 4, IorD=1 gives mem_addr=ALUOut=4; mem_rdata=32'hDEAD_BEEF; mem_to_reg=1, reg_dst=0, reg_write=1 -> r8=DEADBEEF.
- R-type slt: r1=32'hFFFF_FFFF, r2=1, funct 101010, alu_control=111 -> rd=1. Swap operands -> rd=0.
- beq taken: r1=r2=5, IR=beq imm=3, PC=8. Decode computes ALUOut=PC+12; branch=1 with zero=1 -> PC=20. Repeat with r2=6 -> PC stays 8.
- Jump: PC=32'h1000_0004, IR[25:0]=26'h0000_040, pc_src=10, pc_write=1 -> PC=32'h1000_0100.
- r0 protection plus mid-instruction reset: write 7 to r0 -> reads 0. Assert rstn=0 together with reg_write=1 to r5 -> r5=0, PC=RESET_PC.
